divide: RTL and testbench

DIVIDE -- requirements
Module: divide

---
 rtl/divide_if.sv | 23 ++
 rtl/divide.sv | 119 +++++++++++
 tb/tb_divide.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/divide_if.sv
// Operand/result bundle for the signed 32-bit divider.
// master drives a request; slave is the divider.
interface divide_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero, overflow
  );
endinterface

// File: rtl/divide.sv
// Signed 32-bit restoring divider, one quotient bit per clock on operand magnitudes.
// Signs are applied in a final FIX cycle; divide-by-zero skips the iterations.
module divide (
  input  logic  clk,
  input  logic  rst,
  divide_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t      state_reg;
  logic [5:0]  count_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_work_reg;
  logic [31:0] dmag_reg;
  logic        dividend_neg_reg;
  logic        divisor_neg_reg;
  logic        zero_case_reg;
  logic        ovf_case_reg;
  logic [31:0] quotient_reg;
  logic [31:0] remainder_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        div_zero_reg;
  logic        overflow_reg;

  logic [32:0] shifted;
  logic        trial_ok;
  logic [31:0] trial_diff;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;

  // The difference is below 2^32 whenever the trial succeeds, so 32 bits suffice.
  assign shifted    = {rem_reg, quo_work_reg[31]};
  assign trial_ok   = (shifted >= {1'b0, dmag_reg});
  assign trial_diff = shifted[31:0] - dmag_reg;

  // Magnitude of 0x80000000 wraps to itself and is read as unsigned.
  assign dividend_mag = bus.dividend[31] ? (~bus.dividend + 32'd1) : bus.dividend;
  assign divisor_mag  = bus.divisor[31]  ? (~bus.divisor  + 32'd1) : bus.divisor;

  assign quo_signed = (dividend_neg_reg ^ divisor_neg_reg) ? (~quo_work_reg + 32'd1) : quo_work_reg;
  assign rem_signed = dividend_neg_reg ? (~rem_reg + 32'd1) : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      count_reg        <= 6'd0;
      rem_reg          <= 32'd0;
      quo_work_reg     <= 32'd0;
      dmag_reg         <= 32'd0;
      dividend_neg_reg <= 1'b0;
      divisor_neg_reg  <= 1'b0;
      zero_case_reg    <= 1'b0;
      ovf_case_reg     <= 1'b0;
      quotient_reg     <= 32'd0;
      remainder_reg    <= 32'd0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      div_zero_reg     <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            count_reg        <= 6'd0;
            rem_reg          <= 32'd0;
            quo_work_reg     <= dividend_mag;
            dmag_reg         <= divisor_mag;
            dividend_neg_reg <= bus.dividend[31];
            divisor_neg_reg  <= bus.divisor[31];
            zero_case_reg    <= (bus.divisor == 32'd0);
            ovf_case_reg     <= (bus.dividend == 32'h8000_0000) && (bus.divisor == 32'hFFFF_FFFF);
            div_zero_reg     <= 1'b0;
            overflow_reg     <= 1'b0;
            busy_reg         <= 1'b1;
            state_reg        <= (bus.divisor == 32'd0) ? FIX : ITER;
          end
        end
        ITER: begin
          rem_reg      <= trial_ok ? trial_diff : shifted[31:0];
          quo_work_reg <= {quo_work_reg[30:0], trial_ok};
          count_reg    <= count_reg + 6'd1;
          if (count_reg == 6'd31) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          // For divide-by-zero quo_work still holds |dividend|, so rem sign fix restores it.
          if (zero_case_reg) begin
            quotient_reg  <= 32'hFFFF_FFFF;
            remainder_reg <= dividend_neg_reg ? (~quo_work_reg + 32'd1) : quo_work_reg;
          end else begin
            quotient_reg  <= quo_signed;
            remainder_reg <= rem_signed;
          end
          div_zero_reg <= zero_case_reg;
          overflow_reg <= ovf_case_reg;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.div_zero  = div_zero_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_divide.sv
// Bench for the signed divider: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_divide;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  divide_if bus ();

  divide dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic, truncating division, remainder takes dividend sign.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ovf, output int lat);
    longint la;
    longint lb;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    dz  = (lb == 0);
    ovf = (la == -64'sd2147483648) && (lb == -64'sd1);
    if (dz) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      lat = 1;
    end else begin
      q   = 32'(la / lb);
      r   = 32'(la % lb);
      lat = 33;
    end
  endtask

  // Issues one operation. With b2b set, the caller is already inside a done cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit b2b);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    logic        eovf;
    int          elat;
    int          n;
    ref_div(a, b, eq, er, edz, eovf, elat);
    if (!b2b) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    check({tag, ".busy_on_accept"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(elat));
    check({tag, ".quotient"}, bus.quotient, eq);
    check({tag, ".remainder"}, bus.remainder, er);
    check({tag, ".flags"}, {30'd0, bus.div_zero, bus.overflow}, {30'd0, edz, eovf});
    check({tag, ".busy_off"}, 32'(bus.busy), 32'd0);
    $display("op %s: %h / %h -> q=%h r=%h dz=%b ovf=%b lat=%0d", tag, a, b,
             bus.quotient, bus.remainder, bus.div_zero, bus.overflow, n);
  endtask

  task automatic done_falls(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".done_falls"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          pulses;
    logic [31:0] cap_q;
    logic [31:0] cap_r;
    logic [31:0] ra;
    logic [31:0] rb;
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 32'd5;
    bus.divisor  = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.q", bus.quotient, 32'd0);
    check("reset.r", bus.remainder, 32'd0);
    check("reset.ctl", {28'd0, bus.busy, bus.done, bus.div_zero, bus.overflow}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;

    do_op("100/7", 32'd100, 32'd7, 1'b0);
    done_falls("100/7");
    do_op("-100/7", -32'sd100, 32'd7, 1'b0);
    do_op("100/-7", 32'd100, -32'sd7, 1'b0);
    do_op("7/0", 32'd7, 32'd0, 1'b0);
    done_falls("7/0");
    do_op("9/3", 32'd9, 32'd3, 1'b0);
    do_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("-7/0", -32'sd7, 32'd0, 1'b0);
    do_op("min/1", 32'h8000_0000, 32'd1, 1'b0);
    // Back-to-back: start issued in the done cycle.
    do_op("b2b_a", 32'd1000, 32'd33, 1'b1);

    // Reset in mid-iteration aborts without a done pulse.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("abort.q", bus.quotient, 32'd0);
    check("abort.r", bus.remainder, 32'd0);
    check("abort.ctl", {28'd0, bus.busy, bus.done, bus.div_zero, bus.overflow}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    pulses    = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("abort.no_done", 32'(pulses), 32'd0);
    do_op("20/6", 32'd20, 32'd6, 1'b0);

    // A start while busy is ignored.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses    = 0;
    cap_q     = 32'hDEAD_BEEF;
    cap_r     = 32'hDEAD_BEEF;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        pulses++;
        cap_q = bus.quotient;
        cap_r = bus.remainder;
      end
    end
    check("ignore.pulses", 32'(pulses), 32'd1);
    check("ignore.q", cap_q, 32'd10);
    check("ignore.r", cap_r, 32'd0);

    // Random operands, with zero and small divisors mixed in and random back-to-back.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($signed(32'($urandom_range(0, 30))) - 32'sd15);
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op($sformatf("rnd%0d", i), ra, rb, (i > 0) && ($urandom_range(0, 1) == 1));
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
